// File: rtl/wb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : wb_slave_mem
//  Description : Wishbone classic slave with a small register-file memory,
//                programmable wait states, error termination for illegal
//                accesses and a doorbell interrupt on the last word.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_slave_mem #(
  parameter int unsigned   AW          = 8,
  parameter int unsigned   DW          = 8,
  parameter logic [AW-1:0] BASE_ADDR   = 8'hF0,
  parameter int unsigned   DEPTH       = 16,
  parameter int unsigned   WAIT_STATES = 1
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  input  logic          WE_I,
  input  logic          SEL_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          INT_O
);

  localparam int unsigned   c_IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(DEPTH - 1);
  localparam logic [3:0]    c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [c_IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     dato_q, dato_d;
  logic              int_q, int_d;
  logic [DW-1:0]     mem_q [DEPTH];

  // Address decode of the live bus request
  logic              w_req;
  logic [AW-1:0]     w_off;
  logic              w_legal;
  logic [c_IW-1:0]   w_idx;

  // Commit of a legal access on the edge that enters RESP
  logic              w_commit;
  logic [c_IW-1:0]   w_c_idx;
  logic [DW-1:0]     w_c_dat;
  logic              w_c_we;
  logic              w_mem_we;

  assign w_req   = CYC_I & STB_I;
  assign w_off   = ADR_I - BASE_ADDR;
  // No-wrap decode: below base is rejected before the offset is trusted
  assign w_legal = (ADR_I >= BASE_ADDR) && (32'(w_off) < DEPTH) && SEL_I;
  assign w_idx   = w_off[c_IW-1:0];

  // Next-state, commit and output decode; defaults hold every register
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dat_d    = dat_q;
    we_d     = we_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dato_d   = dato_q;
    int_d    = int_q;
    w_commit = 1'b0;
    w_c_idx  = idx_q;
    w_c_dat  = dat_q;
    w_c_we   = we_q;
    w_mem_we = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          idx_d = w_idx;
          dat_d = DAT_I;
          we_d  = WE_I;
          if (!w_legal) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            // Zero wait states: commit straight from the live bus
            state_d  = ST_RESP;
            w_commit = 1'b1;
            w_c_idx  = w_idx;
            w_c_dat  = DAT_I;
            w_c_we   = WE_I;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = c_WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          // Master abandoned the cycle: nothing is written or answered
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d  = ST_RESP;
          w_commit = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_commit) begin
      ack_d = 1'b1;
      if (w_c_we) begin
        w_mem_we = 1'b1;
        if (w_c_idx == c_LAST_IDX) int_d = 1'b1;
      end else begin
        dato_d = mem_q[w_c_idx];
        if (w_c_idx == c_LAST_IDX) int_d = 1'b0;
      end
    end
  end

  // State and control registers; reset wins over any bus activity
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dato_q  <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dato_q  <= dato_d;
      int_q   <= int_d;
    end
  end

  // Storage array; cleared on reset, written only by a committed legal write
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (w_mem_we) begin
      mem_q[w_c_idx] <= w_c_dat;
    end
  end

  assign DAT_O = dato_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign INT_O = int_q;

endmodule
`default_nettype wire
